sensor_trace_buffer: RTL

Capture-and-dump buffer between the TDC decoder (`tdc_decode`, 8-bit coded delay per cycle) and the UART transmitter (`uart_tx`). An `arm` pulse records a fixed-length burst of sensor samples into on-chip RAM, tagging cycles in which the crypto core reports completion. It then streams the whole trace out byte-by-byte using the UART's data-valid/done handshake. This replaces the ad-hoc capture loop and send loop currently spread across the top-level FSMs.

---
 rtl/trace_pkg.sv | 20 ++
 rtl/trace_ram.sv | 27 ++
 rtl/sensor_trace_buffer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/trace_pkg.sv
// Shared types and constants for the sensor trace buffer.
// Holds the capture/dump state encoding, the marker bytes and default sizes.
package trace_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_RD,
        S_LOAD,
        S_WAIT,
        S_FINISH
    } state_t;

    localparam logic [7:0] START_MARK = 8'hFA;
    localparam logic [7:0] MARK       = 8'hFF;

    localparam int DEF_DEPTH = 2048;
    localparam int DEF_AW    = 11;

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port trace RAM: one write port, one registered read port.
// Ports: clk, we/waddr/wdata (write), raddr/q (read, one-cycle latency).
module trace_ram
    import trace_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = DEF_AW,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] q
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        q <= mem[raddr];
    end

endmodule

// File: rtl/sensor_trace_buffer.sv
// Captures DEPTH sensor samples on arm, then streams them out via uart_tx.
// Ports: clk, rstn, arm, sample_i, marker_i, tx_done_i in;
//        busy_o, tx_dv_o, tx_byte_o, done_o out.
// Build option: TRACE_MARKER_EN stores START_MARK in slot 0 and MARK on
// cycles flagged by marker_i; without it marker_i is ignored.
module sensor_trace_buffer
    import trace_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = DEF_AW,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          arm,
    input  logic [DW-1:0] sample_i,
    input  logic          marker_i,
    output logic          busy_o,
    output logic          tx_dv_o,
    output logic [7:0]    tx_byte_o,
    input  logic          tx_done_i,
    output logic          done_o
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    localparam logic [AW-1:0] ONE  = AW'(1);

    state_t        state;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;

    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_q;

`ifdef TRACE_MARKER_EN
    // Slot 0 always carries the start mark, so a marker in the arm
    // cycle is deliberately dropped.
    always_comb begin
        ram_wdata = marker_i ? DW'(MARK) : sample_i;
        if (state == S_IDLE) begin
            ram_wdata = DW'(START_MARK);
        end
    end
`else
    logic unused_marker;
    assign unused_marker = marker_i;
    assign ram_wdata     = sample_i;
`endif

    // Writes happen in the arm cycle (slot 0) and every capture cycle.
    assign ram_we    = (state == S_IDLE && arm) || (state == S_CAPTURE);
    assign ram_waddr = (state == S_IDLE) ? '0 : wr_addr;

    trace_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (rd_addr),
        .q     (ram_q)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            wr_addr   <= '0;
            rd_addr   <= '0;
            busy_o    <= 1'b0;
            tx_dv_o   <= 1'b0;
            tx_byte_o <= '0;
            done_o    <= 1'b0;
        end else begin
            tx_dv_o <= 1'b0;
            done_o  <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (arm) begin
                        wr_addr <= ONE;
                        busy_o  <= 1'b1;
                        state   <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    wr_addr <= wr_addr + ONE;
                    if (wr_addr == LAST) begin
                        rd_addr <= '0;
                        state   <= S_RD;
                    end
                end
                S_RD: begin
                    state <= S_LOAD;
                end
                S_LOAD: begin
                    tx_byte_o <= 8'(ram_q);
                    tx_dv_o   <= 1'b1;
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    if (tx_done_i) begin
                        if (rd_addr == LAST) begin
                            done_o <= 1'b1;
                            busy_o <= 1'b0;
                            state  <= S_FINISH;
                        end else begin
                            rd_addr <= rd_addr + ONE;
                            state   <= S_RD;
                        end
                    end
                end
                S_FINISH: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
